// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit 7-segment
// display. Drives one anode per SHOW slot, separated by an all-dark BLANK
// gap, and swaps in new display data only at frame boundaries so a scan
// never mixes old and new digits.
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        enable,
  input  logic        upd_valid,
  input  logic [15:0] upd_value,
  input  logic [3:0]  upd_dp,
  input  logic        upd_lzs,
  output logic        upd_ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] B_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : CW'(0);

  localparam bit NO_BLANK  = (BLANK_CYCLES == 0);
  localparam bit ONE_DIGIT = (DIGIT_CYCLES == 1);
  localparam bit ONE_BLANK = (BLANK_CYCLES == 1);

  // {an, seg, dp} with every anode, segment and decimal point off
  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t         st_reg;
  logic [1:0]     idx_reg;
  logic [CW-1:0]  cnt_reg;

  logic [15:0]    act_value_reg;
  logic [3:0]     act_dp_reg;
  logic           act_lzs_reg;
  logic [15:0]    pend_value_reg;
  logic [3:0]     pend_dp_reg;
  logic           pend_lzs_reg;
  logic           ready_reg;

  logic [6:0]     seg_reg;
  logic [3:0]     an_reg;
  logic           dp_reg;
  logic           fd_reg;

  logic           last_show;
  logic           last_blank;
  logic           boundary;
  logic           commit;
  logic [15:0]    act_value_next;
  logic [3:0]     act_dp_next;
  logic           act_lzs_next;
  logic [3:0]     sup_next;
  logic [1:0]     idx_inc;
  logic [CW-1:0]  cnt_inc;

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // {an, seg, dp} for a SHOW slot of digit k; a suppressed digit stays dark
  function automatic logic [11:0] digit_out(input logic [1:0]  k,
                                            input logic [15:0] v,
                                            input logic [3:0]  d,
                                            input logic [3:0]  sup);
    logic [11:0] r;
    if (sup[k]) begin
      r = DARK;
    end else begin
      r = {~(4'b0001 << k), hex7(v[4*k +: 4]), ~d[k]};
    end
    return r;
  endfunction

  assign idx_inc    = idx_reg + 2'd1;
  assign cnt_inc    = cnt_reg + CW'(1);
  assign last_show  = (st_reg == SHOW)  && (cnt_reg == D_LAST);
  assign last_blank = (st_reg == BLANK) && (cnt_reg == B_LAST);

  // The boundary cycle is the final cycle of digit 3's slot (its blank, or
  // its show when there is no blank); the commit lands on the edge ending it.
  assign boundary = enable && (idx_reg == 2'd3) && (NO_BLANK ? last_show : last_blank);
  assign commit   = !ready_reg && ((st_reg == IDLE) || boundary);

  // Decode for the next SHOW slot must see data committed on that same edge
  assign act_value_next = commit ? pend_value_reg : act_value_reg;
  assign act_dp_next    = commit ? pend_dp_reg    : act_dp_reg;
  assign act_lzs_next   = commit ? pend_lzs_reg   : act_lzs_reg;

  // Digit k>0 is blanked when it and every more-significant nibble are zero
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sup
      if (gi == 0) begin : g_lsd
        assign sup_next[gi] = 1'b0;
      end else begin : g_upper
        assign sup_next[gi] = act_lzs_next && (act_value_next[15:4*gi] == '0);
      end
    end
  endgenerate

  // Update handshake: capture into the single pending slot, promote on commit
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ready_reg      <= 1'b1;
      pend_value_reg <= '0;
      pend_dp_reg    <= '0;
      pend_lzs_reg   <= 1'b0;
      act_value_reg  <= '0;
      act_dp_reg     <= '0;
      act_lzs_reg    <= 1'b0;
    end else begin
      if (upd_valid && ready_reg) begin
        pend_value_reg <= upd_value;
        pend_dp_reg    <= upd_dp;
        pend_lzs_reg   <= upd_lzs;
        ready_reg      <= 1'b0;
      end else if (commit) begin
        ready_reg <= 1'b1;
      end
      act_value_reg <= act_value_next;
      act_dp_reg    <= act_dp_next;
      act_lzs_reg   <= act_lzs_next;
    end
  end

  // Scan FSM; outputs are registered alongside the state/idx they describe
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_reg                   <= IDLE;
      idx_reg                  <= 2'd0;
      cnt_reg                  <= '0;
      {an_reg, seg_reg, dp_reg} <= DARK;
      fd_reg                   <= 1'b0;
    end else if (!enable) begin
      st_reg                   <= IDLE;
      idx_reg                  <= 2'd0;
      cnt_reg                  <= '0;
      {an_reg, seg_reg, dp_reg} <= DARK;
      fd_reg                   <= 1'b0;
    end else begin
      case (st_reg)
        IDLE: begin
          st_reg                   <= SHOW;
          idx_reg                  <= 2'd0;
          cnt_reg                  <= '0;
          {an_reg, seg_reg, dp_reg} <= digit_out(2'd0, act_value_next, act_dp_next, sup_next);
          fd_reg                   <= 1'b0;
        end
        SHOW: begin
          if (cnt_reg == D_LAST) begin
            cnt_reg <= '0;
            if (NO_BLANK) begin
              st_reg                   <= SHOW;
              idx_reg                  <= idx_inc;
              {an_reg, seg_reg, dp_reg} <= digit_out(idx_inc, act_value_next, act_dp_next, sup_next);
              fd_reg                   <= ONE_DIGIT && (idx_inc == 2'd3);
            end else begin
              st_reg                   <= BLANK;
              {an_reg, seg_reg, dp_reg} <= DARK;
              fd_reg                   <= ONE_BLANK && (idx_reg == 2'd3);
            end
          end else begin
            cnt_reg <= cnt_inc;
            fd_reg  <= NO_BLANK && (idx_reg == 2'd3) && (cnt_inc == D_LAST);
          end
        end
        BLANK: begin
          if (cnt_reg == B_LAST) begin
            st_reg                   <= SHOW;
            idx_reg                  <= idx_inc;
            cnt_reg                  <= '0;
            {an_reg, seg_reg, dp_reg} <= digit_out(idx_inc, act_value_next, act_dp_next, sup_next);
            fd_reg                   <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
            fd_reg  <= (idx_reg == 2'd3) && (cnt_inc == B_LAST);
          end
        end
        default: begin
          st_reg                   <= IDLE;
          idx_reg                  <= 2'd0;
          cnt_reg                  <= '0;
          {an_reg, seg_reg, dp_reg} <= DARK;
          fd_reg                   <= 1'b0;
        end
      endcase
    end
  end

  assign upd_ready  = ready_reg;
  assign seg        = seg_reg;
  assign an         = an_reg;
  assign dp         = dp_reg;
  assign frame_done = fd_reg;

endmodule
